control_sequencer: RTL
======================

Name: control_sequencer

Overview:
Hardwired Mini-RISC control unit. Steps each instruction through fetch (T0-T2) and execute (T3-T7) one step per clock. Drives datapath strobes, including Gra/Grb/Grc/Rin/Rout/BAout for the register select-and-encode stage directly downstream. Decodes the opcode from IR[31:27]; JAL = 5'd20.

Parameters:
ADD_OP, 5'd3, alu_op value used for address and branch-target adds
HALT_OP, 5'd27, opcode that parks the sequencer

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
stop  in  1  halt request, sampled only at instruction boundary
IR  in  32  instruction register contents, valid from T3
CON  in  1  branch condition flip-flop output
run  out  1  high while sequencing, low in HALT and reset
PCout, PCin, IncPC  out  1 each  PC strobes
MARin, MDRin, MDRout  out  1 each  memory address/data register strobes
Read, Write  out  1 each  memory strobes
IRin, Yin, Zin, Zlowout, Cout, CONin  out  1 each  datapath strobes
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  to register select/encode
alu_op  out  5  ALU operation code

Behaviour:
- State register steps RST, T0..T7, HALT. Reset (async) forces RST; all strobes 0, alu_op 0, run 0.
- Strobes are a combinational decode of the current step and IR. Every strobe not listed for a step is 0. alu_op is 0 unless stated.
- RST: next clock goes to T0, run becomes 1.
- T0: PCout, MARin, IncPC, Zin. T1: Zlowout, PCin, Read, MDRin. T2: MDRout, IRin.
- ALU reg-reg (3-11): T3 Grb,Rout,Yin. T4 Grc,Rout,Zin, alu_op=IR[31:27]. T5 Zlowout,Gra,Rin.
- neg/not (17,18): T3 Grb,Rout,Zin, alu_op=opcode. T4 Zlowout,Gra,Rin.
- addi/andi/ori (12-14): T3 Grb,Rout,Yin. T4 Cout,Zin, alu_op=opcode. T5 Zlowout,Gra,Rin.
- ldi (1): T3 Grb,BAout,Yin. T4 Cout,Zin, alu_op=ADD_OP. T5 Zlowout,Gra,Rin.
- ld (0): T3-T4 as ldi. T5 Zlowout,MARin. T6 Read,MDRin. T7 MDRout,Gra,Rin.
- st (2): T3-T5 as ld. T6 Gra,Rout,MDRin. T7 Write.
- br (19): T3 Gra,Rout,CONin. T4 PCout,Yin. T5 Cout,Zin, alu_op=ADD_OP. T6 Zlowout, plus PCin only if CON=1.
- jal (20): T3 Grb,Rin,PCout (encoder maps Grb to R8). T4 Gra,Rout,PCin.
- jr (21): T3 Gra,Rout,PCin.
- nop (26) and any unlisted opcode: T3 with no strobes.
- HALT_OP: T3 with no strobes, then HALT.
- The last execute step returns to T0. If stop=1 at that edge, go to HALT instead.
- HALT: run=0, no strobes. Exit only via reset.
- Reset mid-instruction aborts immediately. No partial strobe survives. Fetch restarts at T0 one cycle after release.

Optional Feature:
SINGLE_STEP_EN
- Defined: adds input step (1 bit). The step register advances only on edges where step=1. Strobes are gated by step, so holding a step never repeats IncPC, Rin, or Write.
- Undefined: no step port; advances every clock.

Test Plan:
- Reset, then IR=0x18918000 (add R1,R2,R3) -> T3 Grb&Rout&Yin. T4 Grc&Rout&Zin with alu_op=3. T5 Gra&Rin&Zlowout. Next cycle T0: PCout&MARin&IncPC&Zin (6 cycles total).
- IR=0x00800010 (ld R1,0x10(R0)) -> T3 BAout&Grb&Yin. T5 MARin. T6 Read&MDRin. T7 MDRout&Gra&Rin. 8-cycle instruction.
- IR=0x98000000 (br), CON=0 then CON=1 -> PCin absent vs present at T6. Zlowout present at T6 in both cases.
- IR=0xA2800000 (jal R5) -> T3 Grb&Rin&PCout. T4 Gra&Rout&PCin. Next T0.
- IR=0xD8000000 (halt) -> run falls after T3. Zero strobes for 20 cycles. Reset pulse restores run=1 and T0.
- Reset asserted during T4 of add -> all outputs 0 in the same cycle. After release: RST, then T0 strobes.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Mini-RISC control unit.
// Steps each instruction through fetch (T0-T2) and execute (T3-T7), one step
// per clock, and decodes datapath strobes from the current step and IR[31:27].
// Optional build macro SINGLE_STEP_EN adds a 'step' input: the step register
// advances only when step=1, and strobes are gated by step.
module control_sequencer #(
   parameter logic [4:0] ADD_OP  = 5'd3,
   parameter logic [4:0] HALT_OP = 5'd27
) (
   input  logic        clk,
   input  logic        reset,
`ifdef SINGLE_STEP_EN
   input  logic        step,
`endif
   input  logic        stop,
   input  logic [31:0] IR,
   input  logic        CON,
   output logic        run,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        Read,
   output logic        Write,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Cout,
   output logic        CONin,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic [4:0]  alu_op
);

   typedef enum logic [3:0] {
      ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
   } state_t;

   state_t     state;
   state_t     state_nxt;
   state_t     last_step;

   logic [4:0] opcode;
   logic       op_alu;
   logic       op_unary;
   logic       op_imm;
   logic       op_ldi;
   logic       op_ld;
   logic       op_st;
   logic       op_br;
   logic       op_jal;
   logic       op_jr;
   logic       op_halt;
   logic       unused_ir;

   assign opcode    = IR[31:27];
   assign unused_ir = ^IR[26:0];

   assign op_alu   = (opcode >= 5'd3) && (opcode <= 5'd11);
   assign op_unary = (opcode == 5'd17) || (opcode == 5'd18);
   assign op_imm   = (opcode >= 5'd12) && (opcode <= 5'd14);
   assign op_ldi   = (opcode == 5'd1);
   assign op_ld    = (opcode == 5'd0);
   assign op_st    = (opcode == 5'd2);
   assign op_br    = (opcode == 5'd19);
   assign op_jal   = (opcode == 5'd20);
   assign op_jr    = (opcode == 5'd21);
   assign op_halt  = (opcode == HALT_OP);

   // Final execute step of the current instruction class.
   always_comb begin
      last_step = ST_T3;
      if (op_alu || op_imm || op_ldi)
         last_step = ST_T5;
      else if (op_unary || op_jal)
         last_step = ST_T4;
      else if (op_ld || op_st)
         last_step = ST_T7;
      else if (op_br)
         last_step = ST_T6;
   end

   // Step register; asynchronous reset parks it in RST.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_RST;
`ifdef SINGLE_STEP_EN
      else if (step)
         state <= state_nxt;
`else
      else
         state <= state_nxt;
`endif
   end

   // Next step: linear advance, with the instruction boundary going to T0 or HALT.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RST:  state_nxt = ST_T0;
         ST_T0:   state_nxt = ST_T1;
         ST_T1:   state_nxt = ST_T2;
         ST_T2:   state_nxt = ST_T3;
         ST_T3:   state_nxt = ST_T4;
         ST_T4:   state_nxt = ST_T5;
         ST_T5:   state_nxt = ST_T6;
         ST_T6:   state_nxt = ST_T7;
         ST_T7:   state_nxt = ST_T0;
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_RST;
      endcase
      // The halt opcode always ends at T3 and parks; otherwise stop is honoured only here.
      if ((state inside {ST_T3, ST_T4, ST_T5, ST_T6, ST_T7}) && (state == last_step))
         state_nxt = (op_halt || stop) ? ST_HALT : ST_T0;
   end

   // Strobe decode from the current step and opcode.
   always_comb begin
      run     = (state != ST_RST) && (state != ST_HALT);
      PCout   = 1'b0;
      PCin    = 1'b0;
      IncPC   = 1'b0;
      MARin   = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      Read    = 1'b0;
      Write   = 1'b0;
      IRin    = 1'b0;
      Yin     = 1'b0;
      Zin     = 1'b0;
      Zlowout = 1'b0;
      Cout    = 1'b0;
      CONin   = 1'b0;
      Gra     = 1'b0;
      Grb     = 1'b0;
      Grc     = 1'b0;
      Rin     = 1'b0;
      Rout    = 1'b0;
      BAout   = 1'b0;
      alu_op  = '0;
      case (state)
         ST_T0: begin
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
         end
         ST_T1: begin
            Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
         end
         ST_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
         end
         ST_T3: begin
            if (op_alu || op_imm) begin
               Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
            end else if (op_unary) begin
               Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
            end else if (op_ldi || op_ld || op_st) begin
               Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
            end else if (op_br) begin
               Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
            end else if (op_jal) begin
               Grb = 1'b1; Rin = 1'b1; PCout = 1'b1;
            end else if (op_jr) begin
               Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
            end
         end
         ST_T4: begin
            if (op_alu) begin
               Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
            end else if (op_imm) begin
               Cout = 1'b1; Zin = 1'b1; alu_op = opcode;
            end else if (op_ldi || op_ld || op_st) begin
               Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP;
            end else if (op_unary) begin
               Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (op_br) begin
               PCout = 1'b1; Yin = 1'b1;
            end else if (op_jal) begin
               Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
            end
         end
         ST_T5: begin
            if (op_alu || op_imm || op_ldi) begin
               Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (op_ld || op_st) begin
               Zlowout = 1'b1; MARin = 1'b1;
            end else if (op_br) begin
               Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP;
            end
         end
         ST_T6: begin
            if (op_ld) begin
               Read = 1'b1; MDRin = 1'b1;
            end else if (op_st) begin
               Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
            end else if (op_br) begin
               Zlowout = 1'b1; PCin = CON;
            end
         end
         ST_T7: begin
            if (op_ld) begin
               MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (op_st) begin
               Write = 1'b1;
            end
         end
         default: ;
      endcase
`ifdef SINGLE_STEP_EN
      // A held step must not repeat side effects such as IncPC, Rin or Write.
      if (!step) begin
         PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
         MDRout = 1'b0; Read = 1'b0; Write = 1'b0; IRin = 1'b0; Yin = 1'b0;
         Zin = 1'b0; Zlowout = 1'b0; Cout = 1'b0; CONin = 1'b0; Gra = 1'b0;
         Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
      end
`endif
   end

endmodule
